ternary_select_pipe: RTL
========================

# ternary_select_pipe

Parametrised, handshaked successor to the ternary select array: holds a resident bank of Tn×K×K 2-bit ternary weights. It multiplies each accepted Tn×K×K feature window by those weights (+x, −x or 0) and emits the signed products through a valid/ready output register. Weights are loaded one channel per beat and the kernel-size mode is latched with them. Feature windows therefore stream back-to-back without re-presenting weights. The block sits between the feature line-buffer/window generator and the adder tree.

## Interface
- TN, 4, input channels processed in parallel
- KS, 5, native kernel size (slots per channel = KS*KS)
- KS3, 3, packed small-kernel size for 3×3 mode
- FEATURE_WIDTH, 8, signed two's-complement feature/product width
- KERNEL_WIDTH, 2, ternary weight code width
- TAG_WIDTH, 5, channel/tile tag carried with each window
- MODE_1, 2'd2; MODE_3, 2'd1; MODE_5, 2'd0, kernel-size mode encodings
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accepted when w_valid && w_ready
- w_data  in  KS*KS*KERNEL_WIDTH  one channel's weights, slot 0 in LSBs
- w_mode  in  2  kernel-size mode; sampled on the first beat of a load only
- load_done  out  1  one-cycle pulse after the last (TN-th) weight beat
- f_valid  in  1  feature window valid
- f_ready  out  1  feature window accepted when f_valid && f_ready
- f_data  in  TN*KS*KS*FEATURE_WIDTH  window, channel c slot s at index c*KS*KS+s
- f_tag  in  TAG_WIDTH  tag accompanying the window
- o_valid  out  1  product vector valid
- o_ready  in  1  downstream accepts when o_valid && o_ready
- o_data  out  TN*KS*KS*FEATURE_WIDTH  products, same indexing as f_data
- o_tag  out  TAG_WIDTH  tag of the window in o_data

## Operation
- FSM states: EMPTY, LOAD, RUN.
- EMPTY: w_ready=1, f_ready=0. The first weight beat goes to LOAD.
- LOAD: w_ready=1, f_ready=0. Beat counter n runs 0..TN-1, and beat n writes bank channel n. The beat where n=TN-1 goes to RUN and pulses load_done in the next cycle.
- RUN: w_ready=1, f_ready = !o_valid || o_ready. An accepted weight beat starts a new load: it writes channel 0, latches w_mode, and moves the FSM to LOAD (n=1). With TN=1 that single beat completes the load: the FSM stays in RUN and load_done pulses.
- w_mode is latched into mode_r on beat 0 of every load. Later beats ignore w_mode.
- Weight decode: 01 → +x, 11 → −x (~x+1, truncated to FEATURE_WIDTH), 00/10 → 0. The most-negative input negates to itself, e.g. 8'h80 → 8'h80.
- MODE_5: slot s uses weight slot s of its own channel.
- MODE_3: for s < KS3², slot s uses weight slot s. For KS3² ≤ s < 2·KS3², slot s uses weight slot s−KS3². All other slots output 0.
- MODE_1: every slot of channel c uses weight slot 0 of channel c.
- An undefined mode value (2'd3) behaves as MODE_5.
- Output register: on a feature handshake, o_data/o_tag load the products and tag, and o_valid goes to 1. When o_valid && o_ready with no new handshake, o_valid goes to 0. o_data holds its value while stalled.

## Timing
- Latency: 1 cycle from feature handshake to o_valid. Throughput is 1 window/cycle when o_ready=1.
- Reset values:
  - State EMPTY, n=0, mode_r=MODE_5, bank all 00.
  - o_valid=0, o_data=0, o_tag=0, load_done=0.
  - w_ready=1, f_ready=0 in the first cycle after reset.
- Reset mid-load or mid-stream discards the bank and the output register. A beat presented in the same cycle as rst is not accepted.
- A feature handshake and the first weight beat of a reload in the same RUN cycle: the feature uses the old bank and old mode_r. The new weights take effect only after the reload completes.
- Windows already in the output register are unaffected by a reload. While in LOAD, f_ready=0.
- Back-pressure: with o_valid=1 and o_ready=0, f_ready=0 and o_data/o_tag are stable.

## Test plan
- Reset, then a load in MODE_5 with TN beats where each channel's weights alternate 01,11,00. Stream windows of x=5 → products 5, −5 (8'hFB), 0 per slot, one cycle later. load_done pulses exactly once.
- MODE_3 load, window of all 3s with weight slot k = 01 for even k and 11 for odd k → slots 0–8 and 9–17 give an identical ±3 pattern; slots 18–24 give 0.
- MODE_1, channel 2 weight slot 0 = 11, x=8'h80 → all channel-2 outputs 8'h80. Channel with slot-0 weight 10 → all 0.
- Stream 6 windows with tags 0..5 while o_ready is low on cycles 2–3 → no loss or duplication, tags emerge in order, and o_data is stable during the stall.
- In RUN, present a feature and weight beat 0 of a reload in the same cycle → that window uses the old weights. f_ready=0 for the remaining TN−1 beats, and the next window uses the new weights.
- Assert rst halfway through a load → outputs return to reset values. A subsequent full load and stream is bit-exact.

Source files
------------

// File: rtl/ternary_select_pipe.sv
// Ternary weight select stage: a resident TN x KS x KS bank of 2-bit weights multiplies each
// accepted feature window (+x, -x or 0) into a valid/ready output register.
module ternary_select_pipe #(
  parameter int         TN            = 4,
  parameter int         KS            = 5,
  parameter int         KS3           = 3,
  parameter int         FEATURE_WIDTH = 8,
  parameter int         KERNEL_WIDTH  = 2,
  parameter int         TAG_WIDTH     = 5,
  parameter logic [1:0] MODE_1        = 2'd2,
  parameter logic [1:0] MODE_3        = 2'd1,
  parameter logic [1:0] MODE_5        = 2'd0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [KS*KS*KERNEL_WIDTH-1:0]        w_data,
  input  logic [1:0]                           w_mode,
  output logic                                 load_done,
  input  logic                                 f_valid,
  output logic                                 f_ready,
  input  logic [TN*KS*KS*FEATURE_WIDTH-1:0]    f_data,
  input  logic [TAG_WIDTH-1:0]                 f_tag,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [TN*KS*KS*FEATURE_WIDTH-1:0]    o_data,
  output logic [TAG_WIDTH-1:0]                 o_tag
);

  localparam int SLOTS = KS * KS;
  localparam int SMALL = KS3 * KS3;
  localparam int CW    = (TN > 1) ? $clog2(TN) : 1;
  localparam int WW    = SLOTS * KERNEL_WIDTH;
  localparam int DW    = TN * SLOTS * FEATURE_WIDTH;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t            state, next_state;
  logic [CW-1:0]     n;
  logic [CW-1:0]     beat;
  logic [1:0]        mode_r;
  logic [WW-1:0]     bank [TN];
  logic              w_fire, f_fire, last_beat;
  logic [DW-1:0]     products;

  assign w_ready   = 1'b1;
  assign f_ready   = (state == RUN) && (!o_valid || o_ready);
  assign w_fire    = w_valid && w_ready;
  assign f_fire    = f_valid && f_ready;
  // A beat accepted outside LOAD always starts a fresh load at channel 0.
  assign beat      = (state == LOAD) ? n : '0;
  assign last_beat = (beat == CW'(TN - 1));

  // Weight code feeding output slot s under the given kernel mode; unused slots read as 0.
  function automatic logic [KERNEL_WIDTH-1:0] weight_code(input logic [WW-1:0] row,
                                                          input logic [1:0]  mode,
                                                          input int          s);
    int ws;
    ws = s;
    case (mode)
      MODE_1:  ws = 0;
      MODE_3:  ws = (s < SMALL) ? s : ((s < 2 * SMALL) ? s - SMALL : -1);
      default: ws = s;
    endcase
    if (ws < 0) return '0;
    return row[ws*KERNEL_WIDTH +: KERNEL_WIDTH];
  endfunction

  function automatic logic [FEATURE_WIDTH-1:0] apply_weight(input logic [FEATURE_WIDTH-1:0] x,
                                                            input logic [KERNEL_WIDTH-1:0]  code);
    case (code)
      KERNEL_WIDTH'(1): return x;
      KERNEL_WIDTH'(3): return ~x + FEATURE_WIDTH'(1);
      default:          return '0;
    endcase
  endfunction

  // NOTE: sequential state is written with non-blocking assignments so every register
  // samples pre-edge values; the same-cycle feature/reload overlap relies on this.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    next_state = state;
    if (w_fire) next_state = last_beat ? RUN : LOAD;
  end

  // NOTE: the weight bank is reset explicitly because a reset must discard any partial load.
  always_ff @(posedge clk) begin
    if (rst) begin
      n         <= '0;
      mode_r    <= MODE_5;
      load_done <= 1'b0;
      for (int c = 0; c < TN; c++) bank[c] <= '0;
    end else begin
      load_done <= w_fire && last_beat;
      if (w_fire) begin
        bank[beat] <= w_data;
        if (beat == '0) mode_r <= w_mode;
        n <= last_beat ? '0 : beat + CW'(1);
      end
    end
  end

  always_comb begin
    products = '0;
    for (int c = 0; c < TN; c++) begin
      for (int s = 0; s < SLOTS; s++) begin
        products[(c*SLOTS+s)*FEATURE_WIDTH +: FEATURE_WIDTH] =
          apply_weight(f_data[(c*SLOTS+s)*FEATURE_WIDTH +: FEATURE_WIDTH],
                       weight_code(bank[c], mode_r, s));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tag   <= '0;
    end else if (f_fire) begin
      o_valid <= 1'b1;
      o_data  <= products;
      o_tag   <= f_tag;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
